// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and defaults for the non-blocking data cache.
//   mshr_state_t : lifecycle of a miss entry (FREE -> PEND -> ISSUED -> DONE).
//   mshr_entry_t : one miss entry {state, addr, regD, data}.
//   MSHR_N_DEF   : default miss-entry count (matches the memory stage).
//   REGD_W       : destination-register index width.
package dcache_pkg;

    localparam int MSHR_N_DEF = 4;
    localparam int REGD_W     = 5;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        PEND   = 2'd1,
        ISSUED = 2'd2,
        DONE   = 2'd3
    } mshr_state_t;

    typedef struct packed {
        mshr_state_t       state;
        logic [31:0]       addr;
        logic [REGD_W-1:0] regD;
        logic [31:0]       data;
    } mshr_entry_t;

endpackage

// File: rtl/dcache_mshr_fifo.sv
// mshr_fifo: allocation-ordered table of outstanding load misses.
//   alloc/alloc_addr/alloc_regD : append a new miss at the tail.
//   issue_avail/issue_addr      : oldest not-yet-issued miss (or the one being
//                                 allocated this cycle when nothing older waits).
//   issue                       : outbound slot takes the issue candidate.
//   fill/fill_data              : read response for the oldest ISSUED entry.
//   pop                         : free the head entry (must be DONE).
//   head                        : head entry contents.
//   match_addr/addr_match       : word address matches any live entry.
//   full                        : no free entry.
// MSHR_N must be a power of two so the pointers wrap naturally.
module mshr_fifo
    import dcache_pkg::*;
#(
    parameter int MSHR_N = MSHR_N_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc,
    input  logic [31:0]       alloc_addr,
    input  logic [REGD_W-1:0] alloc_regD,
    input  logic              issue,
    output logic              issue_avail,
    output logic [31:0]       issue_addr,
    input  logic              fill,
    input  logic [31:0]       fill_data,
    input  logic              pop,
    output mshr_entry_t       head,
    input  logic [31:0]       match_addr,
    output logic              addr_match,
    output logic              full
);

    localparam int PW = (MSHR_N > 1) ? $clog2(MSHR_N) : 1;

    mshr_entry_t   ent [MSHR_N];
    logic [PW-1:0] head_ptr, tail_ptr, iss_ptr, fill_ptr;
    logic [PW:0]   count;
    logic          pend_here;
    logic          fill_ok;
    logic          unused_lsb;

    // Issue and fill both proceed in allocation order, so a pointer each is
    // enough; when the issue pointer's entry is not PEND it equals the tail,
    // which lets a fresh allocation go straight to the bus.
    assign pend_here   = (ent[iss_ptr].state == PEND);
    assign issue_avail = pend_here || alloc;
    assign issue_addr  = pend_here ? ent[iss_ptr].addr : alloc_addr;
    assign fill_ok     = fill && (ent[fill_ptr].state == ISSUED);
    assign full        = (count == (PW+1)'(MSHR_N));
    assign head        = ent[head_ptr];
    assign unused_lsb  = ^match_addr[1:0];

    always_comb begin
        addr_match = 1'b0;
        for (int i = 0; i < MSHR_N; i++) begin
            if (ent[i].state != FREE && ent[i].addr[31:2] == match_addr[31:2])
                addr_match = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MSHR_N; i++) ent[i].state <= FREE;
            head_ptr <= '0;
            tail_ptr <= '0;
            iss_ptr  <= '0;
            fill_ptr <= '0;
            count    <= '0;
        end else begin
            if (alloc) begin
                ent[tail_ptr].addr  <= alloc_addr;
                ent[tail_ptr].regD  <= alloc_regD;
                ent[tail_ptr].state <= (issue && !pend_here) ? ISSUED : PEND;
                tail_ptr            <= tail_ptr + PW'(1);
            end
            if (issue) begin
                if (pend_here) ent[iss_ptr].state <= ISSUED;
                iss_ptr <= iss_ptr + PW'(1);
            end
            if (fill_ok) begin
                ent[fill_ptr].data  <= fill_data;
                ent[fill_ptr].state <= DONE;
                fill_ptr            <= fill_ptr + PW'(1);
            end
            if (pop) begin
                ent[head_ptr].state <= FREE;
                head_ptr            <= head_ptr + PW'(1);
            end
            case ({alloc, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dcache_mshr.sv
// dcache_mshr: non-blocking direct-mapped data cache answering the memory
// stage's mmio port, with up to MSHR_N outstanding load misses.
//   mmio_*            : core request (load/store) and combinational response
//                       strobes hit_ack / miss_store / load_done_stall /
//                       passive_stall, plus regD_done and read data.
//   mem_*             : single outbound bus request slot, in-order read returns.
//   hit_count/miss_count : only when DCACHE_STATS_EN is defined; saturating.
// Optional feature macro: DCACHE_STATS_EN.
module dcache_mshr
    import dcache_pkg::*;
#(
    parameter int NLINES = 16,
    parameter int MSHR_N = MSHR_N_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mmio_req,
    input  logic              mmio_lw,
    input  logic [31:0]       mmio_addr,
    input  logic [31:0]       mmio_data_write,
    input  logic [REGD_W-1:0] mmio_regD,
    output logic [31:0]       mmio_data_read,
    output logic              hit_ack,
    output logic              miss_store,
    output logic              load_done_stall,
    output logic              passive_stall,
    output logic [REGD_W-1:0] regD_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int IDX_W = $clog2(NLINES);
    localparam int TAG_W = 30 - IDX_W;

    logic             line_valid [NLINES];
    logic [TAG_W-1:0] line_tag   [NLINES];
    logic [31:0]      line_data  [NLINES];

    logic             ob_valid, ob_we;
    logic [31:0]      ob_addr, ob_wdata;

    mshr_entry_t      head;
    logic             addr_match, full, issue_avail, issue;
    logic [31:0]      issue_addr;
    logic             alloc, store_acc, head_done, line_hit;
    logic [IDX_W-1:0] req_idx, head_idx;
    logic [TAG_W-1:0] req_tag, head_tag;
    logic             unused_lsb;

    assign req_idx    = mmio_addr[IDX_W+1:2];
    assign req_tag    = mmio_addr[31:IDX_W+2];
    assign head_idx   = head.addr[IDX_W+1:2];
    assign head_tag   = head.addr[31:IDX_W+2];
    assign line_hit   = line_valid[req_idx] && (line_tag[req_idx] == req_tag);
    assign unused_lsb = ^{mmio_addr[1:0], head.addr[1:0]};

    mshr_fifo #(.MSHR_N(MSHR_N)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .alloc      (alloc),
        .alloc_addr (mmio_addr),
        .alloc_regD (mmio_regD),
        .issue      (issue),
        .issue_avail(issue_avail),
        .issue_addr (issue_addr),
        .fill       (mem_rvalid),
        .fill_data  (mem_rdata),
        .pop        (head_done),
        .head       (head),
        .match_addr (mmio_addr),
        .addr_match (addr_match),
        .full       (full)
    );

    // Response priority: a finished refill owns the cycle, then secondary
    // loads stall, then hit, then miss allocation; stores wait for both the
    // MSHR and the outbound slot to be clear of them.
    always_comb begin
        hit_ack         = 1'b0;
        miss_store      = 1'b0;
        load_done_stall = 1'b0;
        passive_stall   = 1'b0;
        regD_done       = '0;
        mmio_data_read  = '0;
        alloc           = 1'b0;
        store_acc       = 1'b0;
        head_done       = 1'b0;
        if (!rst) begin
            if (head.state == DONE) begin
                head_done       = 1'b1;
                load_done_stall = 1'b1;
                regD_done       = head.regD;
                mmio_data_read  = head.data;
            end else if (mmio_req) begin
                if (mmio_lw) begin
                    if (addr_match) begin
                        passive_stall = 1'b1;
                    end else if (line_hit) begin
                        hit_ack        = 1'b1;
                        mmio_data_read = line_data[req_idx];
                    end else if (!full) begin
                        miss_store = 1'b1;
                        alloc      = 1'b1;
                    end else begin
                        passive_stall = 1'b1;
                    end
                end else if (addr_match || ob_valid) begin
                    passive_stall = 1'b1;
                end else begin
                    store_acc = 1'b1;
                end
            end
        end
    end

    // Slot reloads only when empty at the start of the cycle; an accepted
    // store takes precedence over a pending read.
    assign issue = !ob_valid && !store_acc && issue_avail;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ob_valid <= 1'b0;
        end else if (ob_valid) begin
            if (mem_ready) ob_valid <= 1'b0;
        end else if (store_acc || issue) begin
            ob_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!ob_valid) begin
            if (store_acc) begin
                ob_we    <= 1'b1;
                ob_addr  <= mmio_addr;
                ob_wdata <= mmio_data_write;
            end else if (issue) begin
                ob_we    <= 1'b0;
                ob_addr  <= issue_addr;
                ob_wdata <= '0;
            end
        end
    end

    assign mem_req   = ob_valid;
    assign mem_we    = ob_valid & ob_we;
    assign mem_addr  = ob_valid ? ob_addr : '0;
    assign mem_wdata = (ob_valid && ob_we) ? ob_wdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NLINES; i++) line_valid[i] <= 1'b0;
        end else if (head_done) begin
            line_valid[head_idx] <= 1'b1;
        end
    end

    // Write-through without write-allocate: a store only touches a line
    // that is already present.
    always_ff @(posedge clk) begin
        if (head_done) begin
            line_tag[head_idx]  <= head_tag;
            line_data[head_idx] <= head.data;
        end else if (store_acc && line_hit) begin
            line_data[req_idx] <= mmio_data_write;
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_ack && hit_count != 32'hFFFF_FFFF)
                hit_count <= hit_count + 32'd1;
            if (miss_store && miss_count != 32'hFFFF_FFFF)
                miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_mshr.sv
// tb_dcache_mshr: directed bench for dcache_mshr. A small in-order bus
// responder returns read data LAT cycles after a read is accepted.
module tb_dcache_mshr;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        mmio_req, mmio_lw;
    logic [31:0] mmio_addr, mmio_data_write;
    logic [4:0]  mmio_regD;
    logic [31:0] mmio_data_read;
    logic        hit_ack, miss_store, load_done_stall, passive_stall;
    logic [4:0]  regD_done;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready, mem_rvalid;
    logic [31:0] mem_rdata;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] d;
        int          due;
    } rsp_t;
    rsp_t rq[$];

    typedef struct {
        logic        req;
        logic        lw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [3:0]  exp_rsp;   // {hit, miss, done, stall}
        logic [31:0] exp_data;
    } vec_t;
    vec_t tbl [9];

    always #5 clk = ~clk;

    dcache_mshr dut (
        .clk            (clk),
        .rst            (rst),
        .mmio_req       (mmio_req),
        .mmio_lw        (mmio_lw),
        .mmio_addr      (mmio_addr),
        .mmio_data_write(mmio_data_write),
        .mmio_regD      (mmio_regD),
        .mmio_data_read (mmio_data_read),
        .hit_ack        (hit_ack),
        .miss_store     (miss_store),
        .load_done_stall(load_done_stall),
        .passive_stall  (passive_stall),
        .regD_done      (regD_done),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_ready      (mem_ready),
        .mem_rvalid     (mem_rvalid),
`ifdef DCACHE_STATS_EN
        .hit_count      (hit_count),
        .miss_count     (miss_count),
`endif
        .mem_rdata      (mem_rdata)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'h0000_CAFE;
        return {16'hD000, a[15:0]};
    endfunction

    function automatic logic [31:0] rsp();
        return {28'd0, hit_ack, miss_store, load_done_stall, passive_stall};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Advance one cycle; returns at posedge+1 with the responder updated.
    task automatic tick();
        rsp_t r;
        @(negedge clk);
        if (mem_req && mem_ready && !mem_we) begin
            r.d   = mem_word(mem_addr);
            r.due = cyc + LAT;
            rq.push_back(r);
        end
        @(posedge clk);
        #1;
        cyc++;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            r          = rq.pop_front();
            mem_rvalid = 1'b1;
            mem_rdata  = r.d;
        end
    endtask

    task automatic drive(input logic lw, input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
        mmio_req        = 1'b1;
        mmio_lw         = lw;
        mmio_addr       = a;
        mmio_data_write = wd;
        mmio_regD       = rd;
    endtask

    task automatic idle();
        mmio_req        = 1'b0;
        mmio_lw         = 1'b0;
        mmio_addr       = '0;
        mmio_data_write = '0;
        mmio_regD       = '0;
    endtask

    task automatic chk_quiet(input string name);
        chk({name, "_rsp"}, rsp(), 32'd0);
        chk({name, "_memreq"}, {30'd0, mem_req, mem_we}, 32'd0);
        chk({name, "_memaddr"}, mem_addr, 32'd0);
        chk({name, "_regd"}, 32'(regD_done), 32'd0);
        chk({name, "_rdata"}, mmio_data_read, 32'd0);
    endtask

    // Wait (bounded) for a refill delivery and check it; starts at posedge+1.
    task automatic wait_done(input string name, input logic [4:0] rd, input logic [31:0] d);
        int n = 0;
        #2;
        while (load_done_stall !== 1'b1 && n < 40) begin
            tick();
            #2;
            n++;
        end
        chk({name, "_seen"}, 32'(load_done_stall), 32'd1);
        chk({name, "_regd"}, 32'(regD_done), 32'(rd));
        chk({name, "_data"}, mmio_data_read, d);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 1'b1, 32'h200, 32'h0,    5'd1, 4'b0100, 32'h0};
        tbl[1] = '{1'b1, 1'b1, 32'h204, 32'h0,    5'd2, 4'b0100, 32'h0};
        tbl[2] = '{1'b1, 1'b1, 32'h208, 32'h0,    5'd3, 4'b0100, 32'h0};
        tbl[3] = '{1'b1, 1'b1, 32'h20C, 32'h0,    5'd4, 4'b0100, 32'h0};
        tbl[4] = '{1'b1, 1'b1, 32'h210, 32'h0,    5'd6, 4'b0001, 32'h0};
        tbl[5] = '{1'b1, 1'b1, 32'h204, 32'h0,    5'd2, 4'b0001, 32'h0};
        tbl[6] = '{1'b1, 1'b1, 32'h100, 32'h0,    5'd7, 4'b1000, 32'h0000_CAFE};
        tbl[7] = '{1'b1, 1'b0, 32'h100, 32'hDEAD, 5'd0, 4'b0001, 32'h0};
        tbl[8] = '{1'b0, 1'b0, 32'h0,   32'h0,    5'd0, 4'b0000, 32'h0};

        rst        = 1'b1;
        mem_ready  = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        idle();

        // reset state
        repeat (2) @(posedge clk);
        #3;
        chk_quiet("reset_hold");
        @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        chk_quiet("reset_rel");
        tick();

        // cold load
        drive(1'b1, 32'h100, 32'h0, 5'd5); #2;
        chk("cold_miss", rsp(), 32'b0100);
        chk("cold_noreq_c0", 32'(mem_req), 32'd0);
        tick();
        idle(); #2;
        chk("cold_memreq", {30'd0, mem_req, mem_we}, 32'b10);
        chk("cold_memaddr", mem_addr, 32'h100);
        tick(); tick(); #2;
        tick(); #2;
        chk("cold_notyet", 32'(load_done_stall), 32'd0);
        tick(); #2;
        chk("cold_done", rsp(), 32'b0010);
        chk("cold_regd", 32'(regD_done), 32'd5);
        chk("cold_data", mmio_data_read, 32'h0000_CAFE);
        tick();
        drive(1'b1, 32'h100, 32'h0, 5'd5); #2;
        chk("cold_rehit", rsp(), 32'b1000);
        chk("cold_rehit_data", mmio_data_read, 32'h0000_CAFE);
        tick();

        // fill the MSHR with the bus held off
        mem_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].req) drive(tbl[i].lw, tbl[i].addr, tbl[i].wdata, tbl[i].rd);
            else            idle();
            #2;
            chk($sformatf("tbl%0d_rsp", i), rsp(), 32'(tbl[i].exp_rsp));
            if (tbl[i].exp_rsp[3]) chk($sformatf("tbl%0d_data", i), mmio_data_read, tbl[i].exp_data);
            tick();
        end
        #2;
        chk("full_held_addr", mem_addr, 32'h200);
        chk("full_held_req", {30'd0, mem_req, mem_we}, 32'b10);
        tick();
        mem_ready = 1'b1;
        wait_done("refill1", 5'd1, mem_word(32'h200));
        wait_done("refill2", 5'd2, mem_word(32'h204));
        wait_done("refill3", 5'd3, mem_word(32'h208));
        wait_done("refill4", 5'd4, mem_word(32'h20C));

        // secondary access
        drive(1'b1, 32'h300, 32'h0, 5'd8); #2;
        chk("sec_miss", rsp(), 32'b0100);
        tick();
        drive(1'b1, 32'h300, 32'h0, 5'd9); #2;
        chk("sec_load_stall", rsp(), 32'b0001);
        tick();
        drive(1'b0, 32'h300, 32'h55AA, 5'd0); #2;
        chk("sec_store_stall", rsp(), 32'b0001);
        tick();
        idle();
        wait_done("sec_refill", 5'd8, mem_word(32'h300));
        drive(1'b0, 32'h300, 32'h55AA, 5'd0); #2;
        chk("sec_store_acc", rsp(), 32'b0000);
        tick();
        drive(1'b1, 32'h300, 32'h0, 5'd8); #2;
        chk("sec_hit", rsp(), 32'b1000);
        chk("sec_hit_data", mmio_data_read, 32'h55AA);
        chk("sec_wr_req", {30'd0, mem_req, mem_we}, 32'b11);
        chk("sec_wr_addr", mem_addr, 32'h300);
        chk("sec_wr_data", mem_wdata, 32'h55AA);
        tick();

        // store hit with the bus held off
        mem_ready = 1'b0;
        drive(1'b0, 32'h204, 32'h1234, 5'd0); #2;
        chk("st_acc", rsp(), 32'b0000);
        tick();
        drive(1'b0, 32'h208, 32'h1, 5'd0); #2;
        chk("st_second_stall", rsp(), 32'b0001);
        chk("st_hold1_req", {30'd0, mem_req, mem_we}, 32'b11);
        chk("st_hold1_addr", mem_addr, 32'h204);
        chk("st_hold1_data", mem_wdata, 32'h1234);
        tick();
        idle(); #2;
        chk("st_hold2_addr", mem_addr, 32'h204);
        chk("st_hold2_data", mem_wdata, 32'h1234);
        tick();
        mem_ready = 1'b1; #2;
        chk("st_accept_req", {30'd0, mem_req, mem_we}, 32'b11);
        tick();
        drive(1'b1, 32'h204, 32'h0, 5'd12); #2;
        chk("st_cleared", 32'(mem_req), 32'd0);
        chk("st_hit", rsp(), 32'b1000);
        chk("st_hit_data", mmio_data_read, 32'h1234);
        tick();
        drive(1'b1, 32'h208, 32'h0, 5'd12); #2;
        chk("st_untouched", mmio_data_read, mem_word(32'h208));
        tick();

        // refill collides with a load hit
        drive(1'b1, 32'h41C, 32'h0, 5'd9); #2;
        chk("col_miss", rsp(), 32'b0100);
        tick();
        idle();
        tick(); tick(); tick(); tick();
        drive(1'b1, 32'h204, 32'h0, 5'd12); #2;
        chk("col_done_only", rsp(), 32'b0010);
        chk("col_regd", 32'(regD_done), 32'd9);
        chk("col_data", mmio_data_read, mem_word(32'h41C));
        tick(); #2;
        chk("col_hit_next", rsp(), 32'b1000);
        chk("col_hit_data", mmio_data_read, 32'h1234);
        tick();
        idle();

        // reset with two misses issued, then a late response
        drive(1'b1, 32'h500, 32'h0, 5'd10); #2;
        chk("rst_missA", rsp(), 32'b0100);
        tick();
        drive(1'b1, 32'h504, 32'h0, 5'd11); #2;
        chk("rst_missB", rsp(), 32'b0100);
        tick();
        idle();
        tick(); #2;
        chk("rst_B_issued", mem_addr, 32'h504);
        rst = 1'b1; #1;
        chk_quiet("rst_mid");
        tick();
        rst = 1'b0; #2;
        chk("rst_late_rvalid", 32'(mem_rvalid), 32'd1);
        chk_quiet("rst_after");
`ifdef DCACHE_STATS_EN
        chk("rst_hit_count", hit_count, 32'd0);
        chk("rst_miss_count", miss_count, 32'd0);
`endif
        tick();
        for (int i = 0; i < 4; i++) begin
            #2;
            chk($sformatf("rst_no_done%0d", i), rsp(), 32'd0);
            tick();
        end
        drive(1'b1, 32'h204, 32'h0, 5'd1); #2;
        chk("rst_lines_invalid", rsp(), 32'b0100);
        tick();
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/dcache_mshr.md
# dcache_mshr

Non-blocking data cache responder on the memory stage's mmio port: answers loads and stores in the same cycle, tracks up to four outstanding load misses, and re-injects refill data through `load_done_stall`/`regD_done`. Sits between the memory stage and a single in-order memory bus, and is the responding end of the `mmio_*` handshake the memory stage initiates.

## Interface
- `NLINES`, 16: direct-mapped lines, one 32-bit word each, power of two.
- `MSHR_N`, 4: miss entries; must equal the memory stage's tracking depth.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `mmio_req` in 1: request valid.
- `mmio_lw` in 1: 1 = load, 0 = store.
- `mmio_addr` in 32: byte address; bits [1:0] are ignored.
- `mmio_data_write` in 32: store data.
- `mmio_regD` in 5: load destination register.
- `mmio_data_read` out 32: hit data, or refill data when `load_done_stall` is high.
- `hit_ack`, `miss_store`, `load_done_stall`, `passive_stall` out 1 each: response; at most one is high per cycle.
- `regD_done` out 5: destination register of the refill being delivered.
- `mem_req`, `mem_we` out 1: bus request valid; 1 = write.
- `mem_addr`, `mem_wdata` out 32: bus address and write data.
- `mem_ready` in 1: bus accepts the request this cycle.
- `mem_rvalid` in 1, `mem_rdata` in 32: read response; responses return in order.

## Operation
- Each MSHR entry holds `{state, addr, regD, data}`. States: `FREE`, `PEND` (not yet issued), `ISSUED`, `DONE`. Entries are kept in a FIFO ordered by allocation.
- Per-cycle response priority:
  1. **Head entry is `DONE`:** assert `load_done_stall`, drive `regD_done` = head.regD and `mmio_data_read` = head.data. Write the line (valid, tag, data) and free the head. Any core request this cycle is ignored; the core re-presents it.
  2. **Load whose address matches any non-`FREE` entry:** assert `passive_stall`.
  3. **Load hit:** assert `hit_ack` with the line data.
  4. **Load miss, MSHR not full:** assert `miss_store` and allocate the tail as `PEND`.
  5. **Load miss, MSHR full:** assert `passive_stall`.
  6. **Store, address matches a non-`FREE` entry or outbound slot occupied:** assert `passive_stall`.
  7. **Store accepted:** no response strobe. On a hit, update the line data (write-through, no write-allocate). Load the outbound slot with the write.
- Outbound slot: a single register driving `mem_*`, held stable until `mem_ready`.
  - When empty and no store is accepted this cycle, it loads the oldest `PEND` entry as a read and marks that entry `ISSUED`.
- `mem_rvalid` writes `mem_rdata` into the oldest `ISSUED` entry and marks it `DONE`. A response with no `ISSUED` entry is dropped.
- Index = `addr[$clog2(NLINES)+1:2]`; tag = remaining upper bits.

## Timing
- Hits, stall responses and `miss_store` are combinational, in the same cycle as `mmio_req`.
- Miss path:
  - `miss_store` at cycle N; entry is `PEND` at N+1.
  - `mem_req` asserted from N+1 at the earliest.
  - `mem_rvalid` at cycle M; `load_done_stall` at M+1.
  - Load-miss latency = bus latency + 2 cycles.
- The outbound slot clears on the cycle `mem_ready` is high and can reload the next cycle.
- Reset values:
  - All outputs 0.
  - All entries `FREE`, all lines invalid, outbound slot empty.
  - Stat counters 0.
- Reset mid-operation discards outstanding misses. A `mem_rvalid` arriving after reset is dropped.

## Configuration
- `DCACHE_STATS_EN`:
  - **Defined:** adds `hit_count`, `miss_count` out 32. They increment on `hit_ack` and `miss_store` respectively and saturate at `32'hFFFF_FFFF`.
  - **Undefined:** ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package `dcache_pkg`: `mshr_state_t` enum, `mshr_entry_t` struct, `MSHR_N` default, regD width.
- Sub-module `mshr_fifo`:
  - Allocate, issue-select and fill.
  - Head pop.
  - Address-match vector and full flag.
- The tag/data arrays and the outbound slot live in the top module.

## Test plan
- **Cold load:** load `0x100`, rd=5, memory returns `0xCAFE` after 3 cycles -> `miss_store` in cycle 0, `mem_req` read `0x100` in cycle 1, then `load_done_stall` with `regD_done`=5 and data `0xCAFE`. A repeat load -> `hit_ack` with `0xCAFE`.
- **Fill the MSHR:** 4 misses to `0x200`, `0x204`, `0x208`, `0x20C`, then a 5th miss -> `passive_stall`. Refills are delivered in allocation order.
- **Secondary access:** load `0x300` misses; a load to `0x300` and a store to `0x300` before refill -> `passive_stall` for both. After refill, the store is accepted and a subsequent load hit returns the store data.
- **Store hit:** store `0x1234` to a cached address with `mem_ready` held low for 2 cycles -> line updated and `mem_req` write held stable. A second store during the hold -> `passive_stall`.
- **Collision:** refill `DONE` in the same cycle as a load hit -> only `load_done_stall`, and the hit is answered the next cycle.
- **Reset:** assert `rst` with 2 misses `ISSUED`, then a late `mem_rvalid` -> all outputs 0, no `load_done_stall`. With `DCACHE_STATS_EN` defined, `hit_count` and `miss_count` read 0.
